// File: rtl/mmio_bus.sv
// mmio_bus: registered memory-mapped bus between the core load/store path and
// NUM_SLV external slave regions plus one built-in GPIO register.
// Optional feature: define MMIO_BUS_TIMEOUT_EN to abort slave accesses that
// stay unacknowledged for TIMEOUT BUSY cycles.
module mmio_bus #(
   parameter int unsigned       ADDR_W       = 64,
   parameter int unsigned       DATA_W       = 64,
   parameter int unsigned       NUM_SLV      = 4,
   parameter int unsigned       REGION_SHIFT = 16,
   parameter logic [ADDR_W-1:0] GPIO_ADDR    = ADDR_W'(64'h0000_0000_0000_0F00),
   parameter int unsigned       GPIO_W       = 8,
   parameter int unsigned       TIMEOUT      = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_rw,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   output logic                      rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_exc,
   output logic [NUM_SLV-1:0]        slv_sel,
   output logic                      slv_rw,
   output logic [ADDR_W-1:0]         slv_addr,
   output logic [DATA_W-1:0]         slv_wdata,
   input  logic [NUM_SLV*DATA_W-1:0] slv_rdata,
   input  logic [NUM_SLV-1:0]        slv_ack,
   input  logic [NUM_SLV-1:0]        slv_exc,
   output logic [GPIO_W-1:0]         gpio_out
);

   localparam int unsigned       IDX_W      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int unsigned       BYTES      = DATA_W / 8;
   localparam int unsigned       HI_SHIFT   = REGION_SHIFT + IDX_W;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

   if ((GPIO_W > DATA_W) || (NUM_SLV < 1) || (TIMEOUT < 1)) begin : g_bad_param
      $error("mmio_bus: invalid parameter set");
   end

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [IDX_W-1:0]    req_idx;
   logic                misaligned;
   logic                high_bits;
   logic                bad_idx;
   logic                dec_err;
   logic                is_gpio;
   logic                accept;
   logic [NUM_SLV-1:0]  sel_dec;
   logic                ack_hit;
   logic                exc_hit;
   logic                timeout_hit;
   logic [DATA_W-1:0]   sel_rdata;

   // Address decode of the incoming request
   always_comb begin
      req_idx    = req_addr[REGION_SHIFT +: IDX_W];
      misaligned = |(req_addr & ALIGN_MASK);
      high_bits  = |(req_addr >> HI_SHIFT);
      bad_idx    = (32'(req_idx) >= NUM_SLV);
      dec_err    = misaligned | high_bits | bad_idx;
      is_gpio    = (req_addr == GPIO_ADDR);
      sel_dec    = '0;
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
         sel_dec[i] = (32'(req_idx) == i);
      end
   end

   // Completion from the selected slave only; the one-hot select masks stray acks
   always_comb begin
      ack_hit   = |(slv_ack & slv_sel);
      exc_hit   = |(slv_exc & slv_sel);
      sel_rdata = '0;
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
         if (slv_sel[i]) begin
            sel_rdata = sel_rdata | slv_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef MMIO_BUS_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] busy_cnt;

   // Ack has priority over expiry in the same cycle
   assign timeout_hit = (state == BUSY) && !ack_hit && (busy_cnt == CNT_W'(TIMEOUT - 1));

   // Count BUSY cycles without ack, cleared whenever a new access is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt <= '0;
      end else if (accept) begin
         busy_cnt <= '0;
      end else if ((state == BUSY) && !ack_hit) begin
         busy_cnt <= busy_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               if (is_gpio || dec_err) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            if (ack_hit || timeout_hit) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request capture, slave select, GPIO register and response data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slv_sel   <= '0;
         slv_rw    <= 1'b0;
         slv_addr  <= '0;
         slv_wdata <= '0;
         rsp_rdata <= '0;
         rsp_exc   <= 1'b0;
         gpio_out  <= '0;
      end else begin
         if (accept) begin
            slv_rw    <= req_rw;
            slv_addr  <= req_addr;
            slv_wdata <= req_wdata;
            if (is_gpio) begin
               if (req_rw) begin
                  gpio_out  <= req_wdata[GPIO_W-1:0];
                  rsp_rdata <= '0;
               end else begin
                  rsp_rdata <= DATA_W'(gpio_out);
               end
               rsp_exc <= 1'b0;
            end else if (dec_err) begin
               rsp_rdata <= '0;
               rsp_exc   <= 1'b1;
            end else begin
               slv_sel <= sel_dec;
            end
         end else if (state == BUSY) begin
            if (ack_hit) begin
               slv_sel   <= '0;
               rsp_exc   <= exc_hit;
               rsp_rdata <= (exc_hit || slv_rw) ? '0 : sel_rdata;
            end else if (timeout_hit) begin
               slv_sel   <= '0;
               rsp_exc   <= 1'b1;
               rsp_rdata <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: table-driven bench for mmio_bus with a response scoreboard.
// Honours MMIO_BUS_TIMEOUT_EN to select the timeout or wait-forever vectors.
module tb_mmio_bus;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic         req_rw;
   logic [63:0]  req_addr;
   logic [63:0]  req_wdata;
   logic         rsp_valid;
   logic [63:0]  rsp_rdata;
   logic         rsp_exc;
   logic [3:0]   slv_sel;
   logic         slv_rw;
   logic [63:0]  slv_addr;
   logic [63:0]  slv_wdata;
   logic [255:0] slv_rdata;
   logic [3:0]   slv_ack;
   logic [3:0]   slv_exc;
   logic [7:0]   gpio_out;

   mmio_bus #(
      .ADDR_W       (64),
      .DATA_W       (64),
      .NUM_SLV      (4),
      .REGION_SHIFT (16),
      .GPIO_ADDR    (64'h0000_0000_0000_0F00),
      .GPIO_W       (8),
      .TIMEOUT      (15)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_exc   (rsp_exc),
      .slv_sel   (slv_sel),
      .slv_rw    (slv_rw),
      .slv_addr  (slv_addr),
      .slv_wdata (slv_wdata),
      .slv_rdata (slv_rdata),
      .slv_ack   (slv_ack),
      .slv_exc   (slv_exc),
      .gpio_out  (gpio_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic [63:0] addr;
      logic [63:0] wdata;
      int unsigned slave;
      int unsigned wait_c;
      logic [63:0] srdata;
      logic        sexc;
      logic [3:0]  stray;
      logic [3:0]  exp_sel;
      logic        exp_exc;
      logic [63:0] exp_rdata;
      logic [7:0]  exp_gpio;
      int unsigned exp_lat;
      int unsigned exp_selc;
   } vec_t;

   typedef struct {
      logic [63:0] rdata;
      logic        exc;
   } exp_t;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];
   vec_t vecs[$];

   localparam logic [63:0] GPIO = 64'h0000_0000_0000_0F00;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic rw, input logic [63:0] addr, input logic [63:0] wdata,
                                input int unsigned slave, input int unsigned wait_c,
                                input logic [63:0] srdata, input logic sexc, input logic [3:0] stray,
                                input logic [3:0] exp_sel, input logic exp_exc,
                                input logic [63:0] exp_rdata, input logic [7:0] exp_gpio);
      vec_t v;
      v.rw = rw; v.addr = addr; v.wdata = wdata; v.slave = slave; v.wait_c = wait_c;
      v.srdata = srdata; v.sexc = sexc; v.stray = stray; v.exp_sel = exp_sel;
      v.exp_exc = exp_exc; v.exp_rdata = exp_rdata; v.exp_gpio = exp_gpio;
      v.exp_lat  = (exp_sel != 4'b0) ? wait_c + 2 : 1;
      v.exp_selc = (exp_sel != 4'b0) ? wait_c + 1 : 0;
      return v;
   endfunction

   // Scoreboard: every response strobe is matched against the oldest expectation
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && rsp_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
         end else begin
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_exc", 64'(rsp_exc), 64'(e.exc));
         end
      end
   end

   task automatic run_vec(input vec_t v, input int idx);
      int          cyc;
      int          sel_cyc;
      bit          got;
      logic [3:0]  tgt;
      exp_t        e;
      tgt = 4'b0001 << v.slave;
      @(negedge clk);
      check($sformatf("v%0d_req_ready", idx), 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_rw    = v.rw;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      for (int i = 0; i < 4; i++) begin
         slv_rdata[i*64 +: 64] = (i == int'(v.slave)) ? v.srdata : (64'hBAD0_0000_0000_0000 | 64'(i));
      end
      slv_exc = ~tgt | (v.sexc ? tgt : 4'b0);
      e.rdata = v.exp_rdata;
      e.exc   = v.exp_exc;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      sel_cyc = 0;
      got = 1'b0;
      while (cyc <= 200) begin
         if (rsp_valid) begin
            got = 1'b1;
            break;
         end
         if (slv_sel != 4'b0) begin
            sel_cyc++;
            if (sel_cyc == 1) begin
               check($sformatf("v%0d_slv_sel", idx), 64'(slv_sel), 64'(v.exp_sel));
               check($sformatf("v%0d_slv_addr", idx), slv_addr, v.addr);
               check($sformatf("v%0d_slv_wdata", idx), slv_wdata, v.wdata);
               check($sformatf("v%0d_slv_rw", idx), 64'(slv_rw), 64'(v.rw));
            end
         end
         if (v.exp_sel != 4'b0 && cyc == int'(v.wait_c) + 1) begin
            slv_ack = tgt | v.stray;
         end else begin
            slv_ack = v.stray;
         end
         @(negedge clk);
         cyc++;
      end
      slv_ack = 4'b0;
      check($sformatf("v%0d_latency", idx), got ? 64'(cyc) : 64'd999, 64'(v.exp_lat));
      check($sformatf("v%0d_sel_cycles", idx), 64'(sel_cyc), 64'(v.exp_selc));
      check($sformatf("v%0d_gpio_out", idx), 64'(gpio_out), 64'(v.exp_gpio));
      @(negedge clk);
      check($sformatf("v%0d_rsp_one_cycle", idx), 64'(rsp_valid), 64'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got no end of test expected finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      vec_t v;
      exp_t e;
      //              rw    addr                      wdata                     sl wt srdata                   sexc  stray    sel      exc   rdata                    gpio
      vecs.push_back(mkv(1'b1, GPIO,                     64'hA5,                   0, 0, 64'h0,                   1'b0, 4'b0000, 4'b0000, 1'b0, 64'h0,                   8'hA5));
      vecs.push_back(mkv(1'b0, GPIO,                     64'h0,                    0, 0, 64'h0,                   1'b0, 4'b0000, 4'b0000, 1'b0, 64'hA5,                  8'hA5));
      vecs.push_back(mkv(1'b0, 64'h0002_0010,            64'h0,                    2, 3, 64'hDEAD_BEEF,           1'b0, 4'b0000, 4'b0100, 1'b0, 64'hDEAD_BEEF,           8'hA5));
      vecs.push_back(mkv(1'b0, 64'h0000_0004,            64'h0,                    0, 0, 64'h0,                   1'b0, 4'b0000, 4'b0000, 1'b1, 64'h0,                   8'hA5));
      vecs.push_back(mkv(1'b0, 64'h0004_0000,            64'h0,                    0, 0, 64'h0,                   1'b0, 4'b0000, 4'b0000, 1'b1, 64'h0,                   8'hA5));
      vecs.push_back(mkv(1'b1, 64'h0004_0000,            64'hFF,                   0, 0, 64'h0,                   1'b0, 4'b0000, 4'b0000, 1'b1, 64'h0,                   8'hA5));
      vecs.push_back(mkv(1'b0, 64'h0001_0008,            64'h0,                    1, 2, 64'h1234,                1'b1, 4'b1000, 4'b0010, 1'b1, 64'h0,                   8'hA5));
      vecs.push_back(mkv(1'b1, 64'h0003_0000,            64'hCAFE,                 3, 0, 64'h5555,                1'b0, 4'b0000, 4'b1000, 1'b0, 64'h0,                   8'hA5));
      vecs.push_back(mkv(1'b0, 64'h0000_0100,            64'h0,                    0, 1, 64'h0123_4567_89AB_CDEF, 1'b0, 4'b0000, 4'b0001, 1'b0, 64'h0123_4567_89AB_CDEF, 8'hA5));
      vecs.push_back(mkv(1'b0, 64'h1000_0000_0000_0000, 64'h0,                    0, 0, 64'h0,                   1'b0, 4'b0000, 4'b0000, 1'b1, 64'h0,                   8'hA5));
      vecs.push_back(mkv(1'b0, 64'h0008_0000,            64'h0,                    0, 0, 64'h0,                   1'b0, 4'b0000, 4'b0000, 1'b1, 64'h0,                   8'hA5));
      vecs.push_back(mkv(1'b1, GPIO + 64'd1,             64'h3C,                   0, 0, 64'h0,                   1'b0, 4'b0000, 4'b0000, 1'b1, 64'h0,                   8'hA5));
      vecs.push_back(mkv(1'b1, GPIO,                     64'hFFFF_FFFF_FFFF_FF5A,  0, 0, 64'h0,                   1'b0, 4'b0000, 4'b0000, 1'b0, 64'h0,                   8'h5A));
      vecs.push_back(mkv(1'b0, GPIO,                     64'h0,                    0, 0, 64'h0,                   1'b0, 4'b0000, 4'b0000, 1'b0, 64'h5A,                  8'h5A));
      vecs.push_back(mkv(1'b0, 64'h0003_0008,            64'h0,                    3, 0, 64'hFEED,                1'b0, 4'b0111, 4'b1000, 1'b0, 64'hFEED,                8'h5A));
`ifdef MMIO_BUS_TIMEOUT_EN
      v = mkv(1'b0, 64'h0000_0200, 64'h0, 0, 1000, 64'h77, 1'b0, 4'b0000, 4'b0001, 1'b1, 64'h0, 8'h5A);
      v.exp_lat  = 16;
      v.exp_selc = 15;
      vecs.push_back(v);
      vecs.push_back(mkv(1'b0, 64'h0000_0208, 64'h0, 0, 14, 64'h88, 1'b0, 4'b0000, 4'b0001, 1'b0, 64'h88, 8'h5A));
`else
      vecs.push_back(mkv(1'b0, 64'h0000_0200, 64'h0, 0, 100, 64'h77, 1'b0, 4'b0000, 4'b0001, 1'b0, 64'h77, 8'h5A));
`endif

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_rw    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      slv_rdata = '0;
      slv_ack   = '0;
      slv_exc   = '0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_rdata", rsp_rdata, 64'd0);
      check("rst_rsp_exc", 64'(rsp_exc), 64'd0);
      check("rst_slv_sel", 64'(slv_sel), 64'd0);
      check("rst_slv_rw", 64'(slv_rw), 64'd0);
      check("rst_slv_addr", slv_addr, 64'd0);
      check("rst_slv_wdata", slv_wdata, 64'd0);
      check("rst_gpio_out", 64'(gpio_out), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i], i);
      end

      // Back-to-back GPIO accesses: second acceptance two cycles after the first
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b1; req_addr = GPIO; req_wdata = 64'h11;
      e.rdata = 64'h0; e.exc = 1'b0; sb.push_back(e);
      @(negedge clk);
      check("b2b_ready_in_resp", 64'(req_ready), 64'd0);
      check("b2b_gpio_written", 64'(gpio_out), 64'h11);
      req_rw = 1'b0; req_wdata = 64'h0;
      e.rdata = 64'h11; e.exc = 1'b0; sb.push_back(e);
      @(negedge clk);
      check("b2b_ready_again", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_rsp_valid", 64'(rsp_valid), 64'd1);
      @(negedge clk);

      // Reset in the middle of a slave access aborts it with no response
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 64'h0001_0000;
      @(negedge clk);
      req_valid = 1'b0;
      check("rstmid_sel_before", 64'(slv_sel), 64'b0010);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_sel_async", 64'(slv_sel), 64'd0);
      check("rstmid_gpio", 64'(gpio_out), 64'd0);
      check("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rstmid_after%0d_ready", i), 64'(req_ready), 64'd1);
         check($sformatf("rstmid_after%0d_rsp", i), 64'(rsp_valid), 64'd0);
      end

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
